// File: rtl/pwm_cmd_scheduler_if.sv
// Command handshake from the UART register mapper (master) into the PWM command scheduler (slave).
interface pwm_cmd_scheduler_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_ch;
    logic [7:0]  cmd_duty;
    logic [7:0]  cmd_pulse_num;
    logic [16:0] cmd_dessert;

    modport master (output cmd_valid, cmd_ch, cmd_duty, cmd_pulse_num, cmd_dessert,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_ch, cmd_duty, cmd_pulse_num, cmd_dessert,
                    output cmd_ready);
endinterface

// File: rtl/pwm_cmd_scheduler.sv
// In-order PWM command FIFO and single-bus dispatcher with load acknowledge supervision.
// Optional macro PWM_SCHED_WAIT_TIMEOUT_EN drops a head command that waits too long on a busy channel.
module pwm_cmd_scheduler #(
    parameter int NUM_CHANNELS = 6,
    parameter int FIFO_DEPTH   = 4,
    parameter int ACK_TIMEOUT  = 16,
    parameter int WAIT_TIMEOUT = 65535
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    pwm_cmd_scheduler_if.slave            cmd,
    input  logic [NUM_CHANNELS-1:0]       ch_busy,
    output logic [NUM_CHANNELS-1:0]       ch_start,
    output logic [7:0]                    ch_duty,
    output logic [7:0]                    ch_pulse_num,
    output logic [16:0]                   ch_dessert,
    output logic                          err_bad_ch,
    output logic                          err_no_ack,
    output logic                          err_wait_to,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   dispatch_cnt,
    output logic                          sched_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef logic [AW:0] level_t;
    localparam level_t FULL_LEVEL = level_t'(FIFO_DEPTH);

    typedef struct packed {
        logic [7:0]  ch;
        logic [7:0]  duty;
        logic [7:0]  pulse_num;
        logic [16:0] dessert;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, CHECK, LOAD, ACK} state_t;

    cmd_t                    mem [FIFO_DEPTH];
    cmd_t                    head;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic                    rst_done;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    state_t                  state;
    logic [7:0]              cur_ch;
    logic                    bad_ch;
    logic                    sel_busy;
    logic [NUM_CHANNELS-1:0] sel_onehot;
    logic [15:0]             ack_cnt;
    logic                    wait_expired;

    assign head  = mem[rd_ptr];
    assign full  = (fifo_level == FULL_LEVEL);
    assign empty = (fifo_level == '0);

    // Ready is held low until the first edge after reset release.
    assign cmd.cmd_ready = rst_done & ~full;
    assign push          = cmd.cmd_valid & cmd.cmd_ready;
    assign pop           = (state == LOAD) || ((state == CHECK) && bad_ch) || wait_expired;
    assign sched_busy    = (state != IDLE) || !empty;
    assign bad_ch        = (cur_ch >= 8'(NUM_CHANNELS));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel_busy   = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (cur_ch == 8'(i)) begin
                sel_busy      = ch_busy[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            rst_done   <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and level alone decide what is valid.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= '{ch: cmd.cmd_ch, duty: cmd.cmd_duty,
                             pulse_num: cmd.cmd_pulse_num, dessert: cmd.cmd_dessert};
        end
    end

`ifdef PWM_SCHED_WAIT_TIMEOUT_EN
    logic [15:0] wait_cnt;

    assign wait_expired = (state == CHECK) && !bad_ch && sel_busy &&
                          (wait_cnt == 16'(WAIT_TIMEOUT - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wait_cnt    <= '0;
            err_wait_to <= 1'b0;
        end else begin
            err_wait_to <= wait_expired;
            if (state == IDLE && !empty)
                wait_cnt <= '0;
            else if (state == CHECK && sel_busy)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign wait_expired = 1'b0;
    assign err_wait_to  = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= IDLE;
            cur_ch       <= '0;
            ch_duty      <= '0;
            ch_pulse_num <= '0;
            ch_dessert   <= '0;
            ch_start     <= '0;
            err_bad_ch   <= 1'b0;
            err_no_ack   <= 1'b0;
            dispatch_cnt <= '0;
            ack_cnt      <= '0;
        end else begin
            ch_start   <= '0;
            err_bad_ch <= 1'b0;
            err_no_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        cur_ch       <= head.ch;
                        ch_duty      <= head.duty;
                        ch_pulse_num <= head.pulse_num;
                        ch_dessert   <= head.dessert;
                        state        <= CHECK;
                    end
                end
                CHECK: begin
                    if (bad_ch) begin
                        err_bad_ch <= 1'b1;
                        state      <= IDLE;
                    end else if (wait_expired) begin
                        state <= IDLE;
                    end else if (!sel_busy) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    ch_start <= sel_onehot;
                    ack_cnt  <= '0;
                    state    <= ACK;
                end
                ACK: begin
                    // Acceptance wins over a timeout landing on the same edge.
                    if (sel_busy) begin
                        dispatch_cnt <= dispatch_cnt + 1'b1;
                        state        <= IDLE;
                    end else if (ack_cnt == 16'(ACK_TIMEOUT - 1)) begin
                        err_no_ack <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_cmd_scheduler.sv
// Directed bench for pwm_cmd_scheduler: dispatch latency, full FIFO, errors, reset and wait timeout.
module tb_pwm_cmd_scheduler;
    localparam int NCH = 6;

    typedef struct {
        int         cyc;
        logic [5:0] onehot;
        logic [7:0] duty;
    } start_t;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic [NCH-1:0] ch_busy;
    logic [NCH-1:0] busy_drv;
    logic [NCH-1:0] ack_busy;
    logic [NCH-1:0] ack_pending;
    logic [NCH-1:0] ch_start;
    logic [7:0]   ch_duty;
    logic [7:0]   ch_pulse_num;
    logic [16:0]  ch_dessert;
    logic         err_bad_ch;
    logic         err_no_ack;
    logic         err_wait_to;
    logic [2:0]   fifo_level;
    logic [15:0]  dispatch_cnt;
    logic         sched_busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_bad = 0;
    int n_noack = 0;
    int n_wto = 0;
    bit auto_ack = 1'b0;
    start_t starts[$];

    pwm_cmd_scheduler_if cmd_bus();

    assign ch_busy = busy_drv | ack_busy;

    pwm_cmd_scheduler #(
        .NUM_CHANNELS(NCH),
        .FIFO_DEPTH  (4),
        .ACK_TIMEOUT (16),
        .WAIT_TIMEOUT(100)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .cmd         (cmd_bus.slave),
        .ch_busy     (ch_busy),
        .ch_start    (ch_start),
        .ch_duty     (ch_duty),
        .ch_pulse_num(ch_pulse_num),
        .ch_dessert  (ch_dessert),
        .err_bad_ch  (err_bad_ch),
        .err_no_ack  (err_no_ack),
        .err_wait_to (err_wait_to),
        .fifo_level  (fifo_level),
        .dispatch_cnt(dispatch_cnt),
        .sched_busy  (sched_busy)
    );

    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    // Channel model: logs load strobes and, when enabled, acknowledges with one cycle of busy.
    initial begin
        ack_busy    = '0;
        ack_pending = '0;
        forever begin
            @(negedge sys_clk);
            if (err_bad_ch)  n_bad++;
            if (err_no_ack)  n_noack++;
            if (err_wait_to) n_wto++;
            if (ch_start != '0) begin
                starts.push_back('{cyc: cyc, onehot: ch_start, duty: ch_duty});
                if (auto_ack) begin
                    ack_busy    = ack_busy | ch_start;
                    ack_pending = ch_start;
                end
            end else if (ack_pending != '0) begin
                ack_busy    = ack_busy & ~ack_pending;
                ack_pending = '0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; holds valid across exactly one rising edge.
    task automatic push_cmd(input logic [7:0] ch, input logic [7:0] duty,
                            input logic [7:0] pn, input logic [16:0] ds);
        cmd_bus.cmd_valid     = 1'b1;
        cmd_bus.cmd_ch        = ch;
        cmd_bus.cmd_duty      = duty;
        cmd_bus.cmd_pulse_num = pn;
        cmd_bus.cmd_dessert   = ds;
        @(posedge sys_clk);
        @(negedge sys_clk);
        cmd_bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_start(output int k);
        for (k = 1; k <= 20; k++) begin
            @(negedge sys_clk);
            if (ch_start != '0) break;
        end
    endtask

    initial begin
        int k;
        int base;
        int saved;
        logic [7:0] exp_duty [4];

        exp_duty[0] = 8'h11; exp_duty[1] = 8'h22; exp_duty[2] = 8'h33; exp_duty[3] = 8'h44;
        sys_rst               = 1'b1;
        busy_drv              = '0;
        cmd_bus.cmd_valid     = 1'b0;
        cmd_bus.cmd_ch        = '0;
        cmd_bus.cmd_duty      = '0;
        cmd_bus.cmd_pulse_num = '0;
        cmd_bus.cmd_dessert   = '0;

        // Reset state
        repeat (2) @(negedge sys_clk);
        check("rst_ready", cmd_bus.cmd_ready, 0);
        check("rst_level", fifo_level, 0);
        check("rst_start", ch_start, 0);
        check("rst_cnt", dispatch_cnt, 0);
        check("rst_sched_busy", sched_busy, 0);
        check("rst_duty", ch_duty, 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("ready_after_rst", cmd_bus.cmd_ready, 1);

        // Single dispatch: strobe visible after edge T+3
        push_cmd(8'd2, 8'h40, 8'd5, 17'h100);
        check("single_level1", fifo_level, 1);
        repeat (2) @(negedge sys_clk);
        check("single_no_early_start", ch_start, 0);
        @(negedge sys_clk);
        check("single_start", ch_start, 6'b000100);
        check("single_duty", ch_duty, 8'h40);
        check("single_pulse", ch_pulse_num, 8'd5);
        check("single_dessert", ch_dessert, 17'h100);
        @(negedge sys_clk);
        check("single_start_one_cycle", ch_start, 0);
        busy_drv = 6'b000100;
        @(negedge sys_clk);
        check("single_cnt", dispatch_cnt, 1);
        check("single_level0", fifo_level, 0);
        check("single_idle", sched_busy, 0);
        check("single_bus_hold", ch_duty, 8'h40);
        busy_drv = '0;
        @(negedge sys_clk);

        // Full FIFO behind a busy channel 0
        busy_drv = 6'b000001;
        base = starts.size();
        for (int i = 0; i < 4; i++) push_cmd(8'd0, exp_duty[i], 8'd1, 17'h10);
        check("full_level", fifo_level, 4);
        check("full_ready", cmd_bus.cmd_ready, 0);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_duty  = 8'h55;
        repeat (2) @(negedge sys_clk);
        cmd_bus.cmd_valid = 1'b0;
        check("full_no_push", fifo_level, 4);
        check("full_no_start", starts.size() - base, 0);
        auto_ack = 1'b1;
        busy_drv = '0;
        for (int i = 0; i < 60 && (starts.size() - base) < 4; i++) @(negedge sys_clk);
        repeat (10) @(negedge sys_clk);
        check("full_dispatches", starts.size() - base, 4);
        if (starts.size() - base == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("full_onehot%0d", i), starts[base+i].onehot, 6'b000001);
                check($sformatf("full_order%0d", i), starts[base+i].duty, exp_duty[i]);
                if (i > 0) check($sformatf("full_gap%0d", i),
                                 starts[base+i].cyc - starts[base+i-1].cyc, 4);
            end
        end
        check("full_cnt", dispatch_cnt, 5);
        check("full_drained", fifo_level, 0);

        // Bad channel
        base  = starts.size();
        saved = n_bad;
        push_cmd(8'd7, 8'h77, 8'd1, 17'h1);
        repeat (10) @(negedge sys_clk);
        check("bad_pulses", n_bad - saved, 1);
        check("bad_no_start", starts.size() - base, 0);
        check("bad_cnt", dispatch_cnt, 5);
        check("bad_level", fifo_level, 0);

        // No acknowledge: error exactly 16 cycles after the strobe
        auto_ack = 1'b0;
        saved = n_noack;
        push_cmd(8'd1, 8'h21, 8'd2, 17'h2);
        wait_start(k);
        check("noack_start", ch_start, 6'b000010);
        for (k = 1; k <= 30; k++) begin
            @(negedge sys_clk);
            if (err_no_ack) break;
        end
        check("noack_delay", k, 16);
        @(negedge sys_clk);
        check("noack_pulses", n_noack - saved, 1);
        check("noack_cnt", dispatch_cnt, 5);

        // Reset while the first of three commands sits in ACK
        push_cmd(8'd4, 8'h61, 8'd1, 17'h3);
        push_cmd(8'd4, 8'h62, 8'd1, 17'h3);
        push_cmd(8'd4, 8'h63, 8'd1, 17'h3);
        wait_start(k);
        check("midrst_start", ch_start, 6'b010000);
        @(negedge sys_clk);
        check("midrst_level_before", fifo_level, 2);
        saved   = n_noack;
        sys_rst = 1'b1;
        #1;
        check("midrst_level", fifo_level, 0);
        check("midrst_cnt", dispatch_cnt, 0);
        check("midrst_duty", ch_duty, 0);
        check("midrst_ready", cmd_bus.cmd_ready, 0);
        check("midrst_sched_busy", sched_busy, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        base = starts.size();
        repeat (10) @(negedge sys_clk);
        check("postrst_no_start", starts.size() - base, 0);
        check("postrst_level", fifo_level, 0);
        check("postrst_no_err", n_noack - saved, 0);
        check("postrst_ready", cmd_bus.cmd_ready, 1);

        // Head command waiting on a permanently busy channel 3
        busy_drv = 6'b001000;
        base  = starts.size();
        saved = n_wto;
        push_cmd(8'd3, 8'h33, 8'd1, 17'h4);
`ifdef PWM_SCHED_WAIT_TIMEOUT_EN
        for (k = 1; k <= 200; k++) begin
            @(negedge sys_clk);
            if (err_wait_to) break;
        end
        check("wait_to_delay", k, 101);
        @(negedge sys_clk);
        check("wait_to_pulses", n_wto - saved, 1);
        check("wait_to_dropped", fifo_level, 0);
`else
        repeat (150) @(negedge sys_clk);
        check("wait_no_pulse", n_wto - saved, 0);
        check("wait_still_queued", fifo_level, 1);
        check("wait_sched_busy", sched_busy, 1);
`endif
        check("wait_no_start", starts.size() - base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pwm_cmd_scheduler.md
Name: pwm_cmd_scheduler

Overview:
- Sits between the UART register mapper and the bank of high-speed PWM channel generators, all in the 50 MHz domain.
- Queues decoded PWM channel commands in a small FIFO and dispatches them in order to the target channel over a shared load bus.
- Holds each command until its target channel reports not-busy, then confirms that the channel accepted the load.
- Reports malformed commands and acceptance failures, and keeps a dispatch counter for UART status readback.

Parameters:
- NUM_CHANNELS, 6, number of PWM channels driven (1..8).
- FIFO_DEPTH, 4, command FIFO depth; power of two, 2..16.
- ACK_TIMEOUT, 16, cycles to wait for ch_busy to rise after ch_start.
- WAIT_TIMEOUT, 65535, cycles a head command may wait for a busy channel (used only with the optional feature).

Ports:
- sys_clk  in  1  scheduler clock (50 MHz domain).
- sys_rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command present from the register mapper.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_ch  in  8  target channel index.
- cmd_duty  in  8  duty number.
- cmd_pulse_num  in  8  pulse count.
- cmd_dessert  in  17  pulse dead/period field.
- ch_busy  in  NUM_CHANNELS  per-channel busy from the PWM generators.
- ch_start  out  NUM_CHANNELS  one-hot load strobe.
- ch_duty  out  8  shared load bus.
- ch_pulse_num  out  8  shared load bus.
- ch_dessert  out  17  shared load bus.
- err_bad_ch  out  1  1-cycle pulse: command dropped because cmd_ch >= NUM_CHANNELS.
- err_no_ack  out  1  1-cycle pulse: channel never raised busy after ch_start.
- err_wait_to  out  1  1-cycle pulse: head command dropped after waiting too long (optional feature).
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- dispatch_cnt  out  16  count of successful dispatches; wraps 0xFFFF -> 0.
- sched_busy  out  1  high when the FSM is not IDLE or the FIFO is not empty.

Behaviour:
- Async reset (sys_rst=1) forces:
  - FSM to IDLE and FIFO flushed (fifo_level=0).
  - cmd_ready=0 while reset is asserted; cmd_ready=1 from the first clock after release.
  - All other outputs (ch_start, load buses, error pulses, dispatch_cnt, sched_busy) to 0.
- Reset mid-dispatch drops the in-flight command with no error pulse.
- Push rule: accept when cmd_valid & cmd_ready at the rising edge.
  - cmd_ready = ~full, with full taken from the registered level.
  - When full, no push is accepted even if a pop happens in the same cycle.
- Pop rule: the head is popped only in LOAD, or when dropped for an error.
  - A push and a pop in the same cycle leave the level unchanged.
- FSM transitions:
  - IDLE: FIFO not empty -> CHECK, registering the head into the load buses.
  - CHECK, bad channel: head.ch >= NUM_CHANNELS -> pulse err_bad_ch, pop, -> IDLE.
  - CHECK, channel free: ch_busy[ch]=0 -> LOAD.
  - CHECK, channel busy: stay in CHECK (in-order; head-of-line blocking is intended).
  - LOAD: ch_start[ch]=1 for exactly one cycle, pop, reset the ack counter, -> ACK.
  - ACK, accepted: ch_busy[ch]=1 -> dispatch_cnt+1, -> IDLE.
  - ACK, timed out: after ACK_TIMEOUT cycles without busy -> pulse err_no_ack, -> IDLE (no retry, no count).
- Load buses hold their values from CHECK entry until the next IDLE->CHECK transition; they are stable during and after ch_start.
- Latency: for a command accepted at edge T into an empty FIFO with the target idle, ch_start is high in the cycle following edge T+3.
- Minimum spacing between two ch_start pulses is 4 cycles (LOAD, ACK with immediate busy, IDLE, CHECK).
- ch_busy is treated as synchronous to sys_clk; no synchroniser is included.

Optional Feature:
- Macro: PWM_SCHED_WAIT_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter runs while in CHECK with the target channel busy.
  - When the counter reaches WAIT_TIMEOUT: pulse err_wait_to, pop the head, -> IDLE.
  - The counter clears on every CHECK entry.
- Not defined:
  - err_wait_to is tied to 0.
  - CHECK waits indefinitely for the channel.

Test Plan:
- Single dispatch: reset, then push ch=2, duty=0x40, pulse=5, dessert=0x100 with ch_busy=0; the bench raises ch_busy[2] one cycle after ch_start -> ch_start=6'b000100 for one cycle at T+3, buses hold the pushed values, dispatch_cnt=1, fifo_level returns to 0.
- Full FIFO: hold ch_busy[0]=1 and push 5 commands for ch0 -> cmd_ready low after 4 accepted, fifo_level=4. Release busy -> four dispatches in push order, each ≥4 cycles apart.
- Bad channel: push ch=7 with NUM_CHANNELS=6 -> err_bad_ch pulses once, no ch_start, dispatch_cnt unchanged.
- No ack: push ch=1 and keep ch_busy=0 -> ch_start pulse, then err_no_ack exactly 16 cycles later, dispatch_cnt unchanged.
- Reset mid-operation: queue 3 commands, assert sys_rst during ACK -> all outputs 0 immediately; after release, fifo_level=0 and no ch_start.
- With PWM_SCHED_WAIT_TIMEOUT_EN and WAIT_TIMEOUT=100: hold ch_busy[3]=1, push ch=3 -> err_wait_to after 100 CHECK cycles, command dropped. Without the macro: no pulse, command still queued.
